// File: rtl/gcd.sv
// 4-bit unsigned GCD by repeated subtraction.
// The datapath holds x, y and result registers; a three-state controller drives their loads and selects.
module gcd (
  input  logic       clk,
  input  logic       clr,
  input  logic       go,
  input  logic [3:0] xin,
  input  logic [3:0] yin,
  output logic [3:0] gcd_out
);

  localparam int unsigned W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Power-up values match the reset values, so a run without clr starts clean.
  state_t         r_state  = IDLE;
  logic [W-1:0]   r_x      = '0;
  logic [W-1:0]   r_y      = '0;
  logic [W-1:0]   r_result = '0;

  // Comparator and larger-minus-smaller subtractor.
  logic           w_eq;
  logic           w_lt;
  logic           w_x_zero;
  logic           w_y_zero;
  logic [W-1:0]   w_diff;

  assign w_eq     = (r_x == r_y);
  assign w_lt     = (r_x < r_y);
  assign w_x_zero = (r_x == W'(0));
  assign w_y_zero = (r_y == W'(0));
  assign w_diff   = w_lt ? W'(r_y - r_x) : W'(r_x - r_y);

  // Controller decode: register loads and result select.
  logic           w_ld_in;
  logic           w_calc;
  logic           w_finish;
  logic           w_res_sel_y;
  logic           w_ld_x_sub;
  logic           w_ld_y_sub;

  always_comb begin
    w_ld_in     = 1'b0;
    w_calc      = 1'b0;
    w_finish    = 1'b0;
    w_res_sel_y = 1'b0;
    w_ld_x_sub  = 1'b0;
    w_ld_y_sub  = 1'b0;
    if (r_state == IDLE) begin
      w_ld_in = go;
    end
    if (r_state == CALC) begin
      w_calc      = 1'b1;
      w_finish    = w_eq || w_x_zero || w_y_zero;
      w_res_sel_y = !w_eq && w_x_zero;
      w_ld_y_sub  = !w_finish && w_lt;
      w_ld_x_sub  = !w_finish && !w_lt;
    end
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    if (go) r_state <= CALC;
        CALC:    if (w_finish) r_state <= DONE;
        DONE:    if (!go) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_x      <= '0;
      r_y      <= '0;
      r_result <= '0;
    end else begin
      if (w_ld_in) begin
        r_x <= xin;
        r_y <= yin;
      end else if (w_calc) begin
        if (w_ld_x_sub) r_x <= w_diff;
        if (w_ld_y_sub) r_y <= w_diff;
      end
      if (w_finish) begin
        r_result <= w_res_sel_y ? r_y : r_x;
      end
    end
  end

  assign gcd_out = r_result;

endmodule

// File: tb/tb_gcd.sv
// Directed bench for gcd: latency, corner operands, reset mid-run and go-handshake behaviour.
module tb_gcd;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       go  = 1'b0;
  logic [3:0] xin = 4'd0;
  logic [3:0] yin = 4'd0;
  logic [3:0] gcd_out;

  int checks = 0;
  int errors = 0;

  gcd dut (
    .clk     (clk),
    .clr     (clr),
    .go      (go),
    .xin     (xin),
    .yin     (yin),
    .gcd_out (gcd_out)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] px [4];
  logic [3:0] py [4];
  logic [3:0] pe [4];
  logic [3:0] prev;
  logic [4:0] y21;

  initial begin
    px[0] = 4'd0; py[0] = 4'd0; pe[0] = 4'd0;
    px[1] = 4'd0; py[1] = 4'd9; pe[1] = 4'd9;
    px[2] = 4'd7; py[2] = 4'd0; pe[2] = 4'd7;
    px[3] = 4'd6; py[3] = 4'd6; pe[3] = 4'd6;

    // Power-up state without clr, then gcd(4,10) loaded at the 10 ns edge.
    #1;
    check("powerup", gcd_out, 4'd0);
    #4;
    go = 1'b1; xin = 4'd4; yin = 4'd10;
    tick();
    check("g4_10_load", gcd_out, 4'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("g4_10_calc", gcd_out, 4'd0);
    end
    tick();
    check("g4_10_result_90ns", gcd_out, 4'd2);

    // go held high in DONE must not restart, even with new operands.
    xin = 4'd3; yin = 4'd3;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("done_hold_go", gcd_out, 4'd2);
    end

    // clr from DONE, then the worst case gcd(15,1) with go toggling and inputs changing.
    clr = 1'b1;
    tick();
    check("clr_from_done", gcd_out, 4'd0);
    clr = 1'b0; go = 1'b1; xin = 4'd15; yin = 4'd1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      check("g15_1_pending", gcd_out, 4'd0);
      if (k < 15) go = ~go;
      if (k == 3) begin
        xin = 4'd6; yin = 4'd4;
      end
    end
    tick();
    check("g15_1_result", gcd_out, 4'd1);
    go = 1'b0;
    tick();
    check("g15_1_idle_hold", gcd_out, 4'd1);

    // Zero and equal operands finish in one CALC cycle.
    prev = 4'd1;
    for (int i = 0; i < 4; i++) begin
      go = 1'b1; xin = px[i]; yin = py[i];
      tick();
      check("corner_load", gcd_out, prev);
      tick();
      check("corner_result", gcd_out, pe[i]);
      go = 1'b0;
      tick();
      prev = pe[i];
    end

    // clr mid-CALC while go stays high, then a normal restart.
    go = 1'b1; xin = 4'd12; yin = 4'd8;
    tick();
    check("g12_8_load", gcd_out, 4'd6);
    tick();
    check("g12_8_calc", gcd_out, 4'd6);
    clr = 1'b1;
    tick();
    check("clr_mid_calc", gcd_out, 4'd0);
    clr = 1'b0; xin = 4'd9; yin = 4'd6;
    tick();
    check("g9_6_load", gcd_out, 4'd0);
    tick();
    check("g9_6_calc1", gcd_out, 4'd0);
    tick();
    check("g9_6_calc2", gcd_out, 4'd0);
    tick();
    check("g9_6_result", gcd_out, 4'd3);
    go = 1'b0;
    tick();

    // Back-to-back runs with operand changes after the load edge.
    go = 1'b1; xin = 4'd8; yin = 4'd12;
    tick();
    check("g8_12_load", gcd_out, 4'd3);
    xin = 4'd1; yin = 4'd1;
    tick();
    check("g8_12_calc1", gcd_out, 4'd3);
    tick();
    check("g8_12_calc2", gcd_out, 4'd3);
    tick();
    check("g8_12_result", gcd_out, 4'd4);
    xin = 4'd2; yin = 4'd2;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("g8_12_no_reload", gcd_out, 4'd4);
    end
    go = 1'b0;
    tick();
    check("g8_12_go_low", gcd_out, 4'd4);
    y21 = 5'd21;
    go = 1'b1; xin = 4'd14; yin = y21[3:0];
    tick();
    check("g14_5_load", gcd_out, 4'd4);
    xin = 4'd0; yin = 4'd0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("g14_5_calc", gcd_out, 4'd4);
    end
    tick();
    check("g14_5_result", gcd_out, 4'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gcd.md
GCD -- requirements
Module: gcd

Interface
REQ-001 Parameter: none; operand and result width fixed at 4 bits, unsigned.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 clr  input  1  reset; synchronous, active-high, sampled on rising clk edge.
REQ-004 go  input  1  start request, level-sensitive, sampled on rising clk edge.
REQ-005 xin  input  4  first operand, unsigned; sampled only when a computation starts.
REQ-006 yin  input  4  second operand, unsigned; sampled only when a computation starts.
REQ-007 gcd_out  output  4  registered result; holds last completed GCD.

Function
REQ-008 The design SHALL be partitioned into a datapath (x, y, result registers; 4-bit comparator; 4-bit subtractor; operand muxes) and an FSM controller driving the register loads and mux selects.
REQ-009 The FSM SHALL have three states: IDLE, CALC, DONE.
REQ-010 IDLE: if go=1, load x<=xin, y<=yin and go to CALC; otherwise remain in IDLE with x, y unchanged.
REQ-011 CALC, one decision per cycle, in priority order:
- x==y: gcd_out<=x, go to DONE.
- x==0: gcd_out<=y, go to DONE.
- y==0: gcd_out<=x, go to DONE.
- x<y: y<=y-x, stay in CALC.
- x>y: x<=x-y, stay in CALC.
REQ-012 DONE: gcd_out held; return to IDLE only when go=0. A go held high SHALL NOT restart a computation; a new start needs go low for at least one cycle.
REQ-013 Subtraction SHALL only be performed larger-minus-smaller; no wrap-around can occur, and x, y never exceed 15.
REQ-014 Latency, counted from the IDLE edge where go=1 is sampled: 1 load cycle plus N CALC cycles, where N = number of subtractions + 1. Worst case is gcd(15,1) or gcd(1,15): 15 CALC cycles.
REQ-015 gcd(0,0)=0; gcd(0,n)=gcd(n,0)=n; gcd(n,n)=n. Each SHALL complete in exactly 1 CALC cycle.
REQ-016 gcd_out SHALL change only on the edge entering DONE or on reset; it SHALL NOT glitch or show intermediate x/y values during CALC.
REQ-017 xin/yin changes after the load edge SHALL NOT affect the computation in progress.
REQ-018 go toggling during CALC SHALL be ignored.

Reset
REQ-019 When clr=1 at a rising edge: state<=IDLE, x<=0, y<=0, gcd_out<=0, regardless of current state, including mid-CALC. clr has priority over go.
REQ-020 All registers SHALL also carry power-up initial values equal to their reset values, so a run that never asserts clr starts in IDLE with gcd_out=0.
REQ-021 On the first edge after clr deasserts with go=1, operands SHALL be loaded normally.

Verification
REQ-022 No clr; clk period 20 ns, first rising edge at 10 ns; go=1, xin=4, yin=10 from 5 ns -> load at 10 ns; y:10->6->2, then x:4->2; gcd_out=2 at the 90 ns edge; FSM stays in DONE while go stays 1.
REQ-023 xin=15, yin=1 -> gcd_out=1 after exactly 1+15 cycles; gcd_out stays 0 on every earlier edge.
REQ-024 Operand pairs (0,0), (0,9), (7,0), (6,6) -> gcd_out 0, 9, 7, 6 respectively, each 2 cycles after go is sampled.
REQ-025 Start (12,8); assert clr for one cycle mid-CALC -> gcd_out=0 and FSM in IDLE on that edge. Then go=1 with (9,6) -> gcd_out=3.
REQ-026 Back-to-back runs:
- Complete (8,12) -> gcd_out=4.
- Keep go=1 -> gcd_out stays 4 with no reload.
- Drop go one cycle, then apply go=1 with (14,21 masked to 4 bits=5) -> gcd_out=1.
- Change xin/yin mid-run -> result unaffected.
